// File: rtl/d_victim_cache_tag_pkg.sv
// Shared definitions for the data-side victim cache tag stage.
// Contents:
//   WAYS_VC / INDEX_WAY_VC / TAG_WIDTH_VC : geometry of the tag store
//   vc_tag_type                           : one tag-store entry {valid, dirty, tag}
//   vc_state_e                            : control FSM states
package cache_def;

  localparam int WAYS_VC      = 4;
  localparam int INDEX_WAY_VC = $clog2(WAYS_VC);
  localparam int TAG_WIDTH_VC = 28;

  typedef struct packed {
    logic                    valid;
    logic                    dirty;
    logic [TAG_WIDTH_VC-1:0] tag;
  } vc_tag_type;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WB    = 2'd1,
    WRITE = 2'd2
  } vc_state_e;

endpackage

// File: rtl/d_victim_cache_tag_if.sv
// Bus bundle between the victim cache tag stage, the L1, the victim data
// array and memory. Signal suffixes are relative to the tag stage.
//   lookup_* / hit_*        : L1 miss probe and its combinational result
//   insert_*                : L1 eviction offer, accepted by insert_ready_o
//   address_way_o/data_we_o : victim data array control
//   wb_*                    : dirty-victim writeback handshake to memory
//   busy_o                  : tag stage is not idle
// Modports: slave = tag stage, master = its environment.
interface d_victim_cache_tag_if;
  import cache_def::*;

  logic                    lookup_valid_i;
  logic [TAG_WIDTH_VC-1:0] lookup_tag_i;
  logic                    hit_o;
  logic [INDEX_WAY_VC-1:0] hit_way_o;
  logic                    hit_dirty_o;
  logic                    insert_valid_i;
  logic [TAG_WIDTH_VC-1:0] insert_tag_i;
  logic                    insert_dirty_i;
  logic                    insert_ready_o;
  logic [INDEX_WAY_VC-1:0] address_way_o;
  logic                    data_we_o;
  logic                    wb_valid_o;
  logic                    wb_ready_i;
  logic [TAG_WIDTH_VC-1:0] wb_tag_o;
  logic                    busy_o;

  modport slave (
    input  lookup_valid_i, lookup_tag_i, insert_valid_i, insert_tag_i,
           insert_dirty_i, wb_ready_i,
    output hit_o, hit_way_o, hit_dirty_o, insert_ready_o, address_way_o,
           data_we_o, wb_valid_o, wb_tag_o, busy_o
  );

  modport master (
    output lookup_valid_i, lookup_tag_i, insert_valid_i, insert_tag_i,
           insert_dirty_i, wb_ready_i,
    input  hit_o, hit_way_o, hit_dirty_o, insert_ready_o, address_way_o,
           data_we_o, wb_valid_o, wb_tag_o, busy_o
  );

endinterface

// File: rtl/d_victim_cache_repl.sv
// Victim way selection for the victim cache.
//   clk_i, rst_ni  : clock, synchronous active-low reset
//   valid_i        : per-way valid bits
//   advance_i      : a FIFO-chosen way was written; step the pointer
//   victim_way_o   : lowest invalid way if any, else the FIFO pointer
module d_victim_cache_repl
  import cache_def::*;
(
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [WAYS_VC-1:0]      valid_i,
  input  logic                    advance_i,
  output logic [INDEX_WAY_VC-1:0] victim_way_o
);

  logic [INDEX_WAY_VC-1:0] ptr_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples values from before the edge, independent of block ordering.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (advance_i) begin
      ptr_q <= ptr_q + 1'b1;  // WAYS_VC is a power of two, so this wraps
    end
  end

  // NOTE: the default is assigned before the loop so no path leaves the
  // output unassigned, which would otherwise infer a latch.
  always_comb begin
    victim_way_o = ptr_q;
    // Scan downwards so the lowest-index invalid way is the last writer.
    for (int i = WAYS_VC - 1; i >= 0; i--) begin
      if (!valid_i[i]) victim_way_o = INDEX_WAY_VC'(i);
    end
  end

endmodule

// File: rtl/d_victim_cache_tag.sv
// Tag/control stage of the data-side victim cache.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   vc            : slave side of d_victim_cache_tag_if (lookup, insert,
//                   data array control, writeback handshake, busy)
// Fully associative tag store with FIFO replacement. A lookup that hits in
// the same cycle as an insert swaps the line into the hit way; a dirty FIFO
// victim is written back (WB) before the new line is written (WRITE).
module d_victim_cache_tag
  import cache_def::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  d_victim_cache_tag_if.slave  vc
);

  vc_tag_type              entries_q [WAYS_VC];
  vc_state_e               state_q, state_d;
  logic [INDEX_WAY_VC-1:0] victim_way_q, victim_way_d;
  logic [TAG_WIDTH_VC-1:0] victim_tag_q, victim_tag_d;

  logic [WAYS_VC-1:0]      valid_vec, match_vec;
  logic [INDEX_WAY_VC-1:0] match_way, repl_way, target_way, commit_way, address_way;
  logic                    hit, swap, fifo_pick, write_now;
  logic                    insert_ready, data_we, wb_valid, advance;
  logic [TAG_WIDTH_VC-1:0] wb_tag;

  d_victim_cache_repl u_repl (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .valid_i      (valid_vec),
    .advance_i    (advance),
    .victim_way_o (repl_way)
  );

  // Comparators; at most one way can match because inserts never duplicate.
  always_comb begin
    valid_vec = '0;
    match_vec = '0;
    match_way = '0;
    for (int i = 0; i < WAYS_VC; i++) begin
      valid_vec[i] = entries_q[i].valid;
      match_vec[i] = entries_q[i].valid && (entries_q[i].tag == vc.lookup_tag_i);
      if (match_vec[i]) match_way = INDEX_WAY_VC'(i);
    end
  end

  assign hit        = rst_ni && vc.lookup_valid_i && (state_q == IDLE) && (|match_vec);
  assign swap       = hit && vc.insert_valid_i;
  assign fifo_pick  = !swap && (&valid_vec);
  assign target_way = swap ? match_way : repl_way;
  // A swapped line moves to the L1, so its dirty bit never forces a writeback.
  assign write_now  = swap || !entries_q[target_way].valid || !entries_q[target_way].dirty;

  always_comb begin
    state_d      = state_q;
    victim_way_d = victim_way_q;
    victim_tag_d = victim_tag_q;
    insert_ready = 1'b0;
    data_we      = 1'b0;
    wb_valid     = 1'b0;
    wb_tag       = '0;
    advance      = 1'b0;
    address_way  = '0;
    commit_way   = target_way;
    case (state_q)
      IDLE: begin
        address_way = vc.insert_valid_i ? target_way : (hit ? match_way : '0);
        if (vc.insert_valid_i) begin
          if (write_now) begin
            insert_ready = 1'b1;
            data_we      = 1'b1;
            advance      = fifo_pick;
          end else begin
            victim_way_d = target_way;
            victim_tag_d = entries_q[target_way].tag;
            state_d      = WB;
          end
        end
      end
      WB: begin
        address_way = victim_way_q;
        wb_valid    = 1'b1;
        wb_tag      = victim_tag_q;
        if (vc.wb_ready_i) state_d = WRITE;
      end
      WRITE: begin
        // Only a valid dirty FIFO victim reaches here, so the pointer steps.
        address_way  = victim_way_q;
        commit_way   = victim_way_q;
        insert_ready = 1'b1;
        data_we      = 1'b1;
        advance      = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // No write may be reported while reset holds the tag store cleared.
    if (!rst_ni) begin
      insert_ready = 1'b0;
      data_we      = 1'b0;
      advance      = 1'b0;
      address_way  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      victim_way_q <= '0;
      victim_tag_q <= '0;
    end else begin
      state_q      <= state_d;
      victim_way_q <= victim_way_d;
      victim_tag_q <= victim_tag_d;
    end
  end

  // NOTE: only valid/dirty are reset; tags are don't-care while invalid, so
  // the tag storage needs no reset path.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < WAYS_VC; i++) begin
        entries_q[i].valid <= 1'b0;
        entries_q[i].dirty <= 1'b0;
      end
    end else if (insert_ready) begin
      entries_q[commit_way] <= '{valid: 1'b1, dirty: vc.insert_dirty_i, tag: vc.insert_tag_i};
    end
  end

  assign vc.hit_o          = hit;
  assign vc.hit_way_o      = hit ? match_way : '0;
  assign vc.hit_dirty_o    = hit && entries_q[match_way].dirty;
  assign vc.insert_ready_o = insert_ready;
  assign vc.data_we_o      = data_we;
  assign vc.address_way_o  = address_way;
  assign vc.wb_valid_o     = wb_valid;
  assign vc.wb_tag_o       = wb_tag;
  assign vc.busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_d_victim_cache_tag.sv
// Self-checking bench for d_victim_cache_tag: directed scenarios followed by
// randomized lookups/inserts/resets, all checked against a transaction-level
// model of the victim cache contents (arrays plus a FIFO pointer).
module tb_d_victim_cache_tag;
  import cache_def::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  d_victim_cache_tag_if vc_if ();

  d_victim_cache_tag dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .vc     (vc_if)
  );

  // Reference model: what the victim cache holds, not how the RTL holds it.
  bit                      m_valid [WAYS_VC];
  bit                      m_dirty [WAYS_VC];
  logic [TAG_WIDTH_VC-1:0] m_tag   [WAYS_VC];
  int                      m_ptr;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic int m_find(input logic [TAG_WIDTH_VC-1:0] t);
    for (int i = 0; i < WAYS_VC; i++)
      if (m_valid[i] && m_tag[i] == t) return i;
    return -1;
  endfunction

  function automatic bit m_full();
    for (int i = 0; i < WAYS_VC; i++)
      if (!m_valid[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int m_target(input int hw);
    if (hw >= 0) return hw;
    for (int i = 0; i < WAYS_VC; i++)
      if (!m_valid[i]) return i;
    return m_ptr;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < WAYS_VC; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = '0;
    end
    m_ptr = 0;
  endtask

  task automatic drive_idle();
    vc_if.lookup_valid_i = 1'b0;
    vc_if.lookup_tag_i   = '0;
    vc_if.insert_valid_i = 1'b0;
    vc_if.insert_tag_i   = '0;
    vc_if.insert_dirty_i = 1'b0;
    vc_if.wb_ready_i     = 1'b0;
  endtask

  // All tasks start and end at posedge+1; checks happen on the falling edge.
  task automatic do_reset();
    rst_n                = 1'b0;
    vc_if.lookup_valid_i = 1'b1;
    vc_if.lookup_tag_i   = m_tag[0];
    vc_if.insert_valid_i = 1'b1;
    vc_if.insert_tag_i   = 28'h77;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_hit", 32'(vc_if.hit_o), 32'd0);
    check("rst_ready", 32'(vc_if.insert_ready_o), 32'd0);
    check("rst_we", 32'(vc_if.data_we_o), 32'd0);
    check("rst_addr", 32'(vc_if.address_way_o), 32'd0);
    check("rst_wb_valid", 32'(vc_if.wb_valid_o), 32'd0);
    check("rst_busy", 32'(vc_if.busy_o), 32'd0);
    drive_idle();
    rst_n = 1'b1;
    m_clear();
    @(posedge clk); #1;
  endtask

  task automatic do_lookup(input logic [TAG_WIDTH_VC-1:0] t);
    int w;
    w = m_find(t);
    vc_if.lookup_valid_i = 1'b1;
    vc_if.lookup_tag_i   = t;
    @(negedge clk);
    check("lk_hit", 32'(vc_if.hit_o), 32'(w >= 0));
    check("lk_way", 32'(vc_if.hit_way_o), (w >= 0) ? 32'(w) : 32'd0);
    check("lk_dirty", 32'(vc_if.hit_dirty_o), (w >= 0) ? 32'(m_dirty[w]) : 32'd0);
    check("lk_addr", 32'(vc_if.address_way_o), (w >= 0) ? 32'(w) : 32'd0);
    check("lk_we", 32'(vc_if.data_we_o), 32'd0);
    check("lk_busy", 32'(vc_if.busy_o), 32'd0);
    @(posedge clk); #1;
    vc_if.lookup_valid_i = 1'b0;
  endtask

  task automatic do_insert(input bit lk, input logic [TAG_WIDTH_VC-1:0] lk_tag,
                           input logic [TAG_WIDTH_VC-1:0] ins_tag, input bit ins_dirty,
                           input int wait_cycles);
    int hw, tgt;
    bit needs_wb, fifo;
    hw       = lk ? m_find(lk_tag) : -1;
    tgt      = m_target(hw);
    fifo     = (hw < 0) && m_full();
    needs_wb = (hw < 0) && m_valid[tgt] && m_dirty[tgt];
    vc_if.lookup_valid_i = lk;
    vc_if.lookup_tag_i   = lk_tag;
    vc_if.insert_valid_i = 1'b1;
    vc_if.insert_tag_i   = ins_tag;
    vc_if.insert_dirty_i = ins_dirty;
    @(negedge clk);
    check("ins_hit", 32'(vc_if.hit_o), 32'(hw >= 0));
    if (hw >= 0) begin
      check("swap_way", 32'(vc_if.hit_way_o), 32'(hw));
      check("swap_dirty", 32'(vc_if.hit_dirty_o), 32'(m_dirty[hw]));
    end
    check("ins_addr", 32'(vc_if.address_way_o), 32'(tgt));
    check("ins_ready", 32'(vc_if.insert_ready_o), 32'(!needs_wb));
    check("ins_we", 32'(vc_if.data_we_o), 32'(!needs_wb));
    check("ins_wb_valid", 32'(vc_if.wb_valid_o), 32'd0);
    if (needs_wb) begin
      @(posedge clk); #1;
      // Probe a line that is present: it must not hit while busy.
      vc_if.lookup_valid_i = 1'b1;
      vc_if.lookup_tag_i   = m_tag[(tgt + 1) % WAYS_VC];
      for (int k = 0; k <= wait_cycles; k++) begin
        vc_if.wb_ready_i = (k == wait_cycles);
        @(negedge clk);
        check("wb_valid", 32'(vc_if.wb_valid_o), 32'd1);
        check("wb_tag", 32'(vc_if.wb_tag_o), 32'(m_tag[tgt]));
        check("wb_addr", 32'(vc_if.address_way_o), 32'(tgt));
        check("wb_busy", 32'(vc_if.busy_o), 32'd1);
        check("wb_hit", 32'(vc_if.hit_o), 32'd0);
        check("wb_ready_out", 32'(vc_if.insert_ready_o), 32'd0);
        @(posedge clk); #1;
      end
      vc_if.wb_ready_i     = 1'b0;
      vc_if.lookup_valid_i = 1'b0;
      @(negedge clk);
      check("wr_ready", 32'(vc_if.insert_ready_o), 32'd1);
      check("wr_we", 32'(vc_if.data_we_o), 32'd1);
      check("wr_addr", 32'(vc_if.address_way_o), 32'(tgt));
      check("wr_wb_valid", 32'(vc_if.wb_valid_o), 32'd0);
      check("wr_busy", 32'(vc_if.busy_o), 32'd1);
    end
    @(posedge clk);
    m_valid[tgt] = 1'b1;
    m_dirty[tgt] = ins_dirty;
    m_tag[tgt]   = ins_tag;
    if (fifo) m_ptr = (m_ptr + 1) % WAYS_VC;
    #1;
    drive_idle();
  endtask

  function automatic logic [TAG_WIDTH_VC-1:0] fresh_tag();
    logic [TAG_WIDTH_VC-1:0] t;
    do t = TAG_WIDTH_VC'($urandom_range(1, 20)); while (m_find(t) >= 0);
    return t;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_idle();
    m_clear();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // First insert lands in way 0 with zero latency.
    do_lookup(28'h10);
    do_insert(1'b0, '0, 28'h10, 1'b0, 0);
    do_lookup(28'h10);

    // Clean FIFO replacement.
    do_reset();
    for (int i = 1; i <= 4; i++) do_insert(1'b0, '0, TAG_WIDTH_VC'(i), 1'b0, 0);
    do_insert(1'b0, '0, 28'h5, 1'b0, 0);
    do_insert(1'b0, '0, 28'h6, 1'b0, 0);
    do_lookup(28'h1);
    do_lookup(28'h6);

    // Dirty victim writeback with ready held low for 3 cycles.
    do_reset();
    do_insert(1'b0, '0, 28'h1, 1'b1, 0);
    for (int i = 2; i <= 4; i++) do_insert(1'b0, '0, TAG_WIDTH_VC'(i), 1'b0, 0);
    do_insert(1'b0, '0, 28'h5, 1'b0, 3);
    do_lookup(28'h5);
    do_lookup(28'h2);

    // Swap with a dirty hit way: no writeback.
    do_reset();
    do_insert(1'b0, '0, 28'h1, 1'b0, 0);
    do_insert(1'b0, '0, 28'h2, 1'b0, 0);
    do_insert(1'b0, '0, 28'h3, 1'b1, 0);
    do_insert(1'b1, 28'h3, 28'h9, 1'b0, 0);
    do_lookup(28'h3);
    do_lookup(28'h9);

    // Reset in the middle of a writeback.
    do_reset();
    for (int i = 1; i <= 4; i++) do_insert(1'b0, '0, TAG_WIDTH_VC'(i), 1'b1, 0);
    vc_if.insert_valid_i = 1'b1;
    vc_if.insert_tag_i   = 28'h5;
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_wb_valid", 32'(vc_if.wb_valid_o), 32'd1);
    rst_n = 1'b0;
    drive_idle();
    @(posedge clk); #1;
    check("mid_rst_wb_valid", 32'(vc_if.wb_valid_o), 32'd0);
    check("mid_rst_busy", 32'(vc_if.busy_o), 32'd0);
    rst_n = 1'b1;
    m_clear();
    @(posedge clk); #1;
    for (int i = 1; i <= 4; i++) do_lookup(TAG_WIDTH_VC'(i));

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r == 0) begin
        do_reset();
      end else if (r < 7) begin
        do_lookup(TAG_WIDTH_VC'($urandom_range(1, 20)));
      end else begin
        logic [TAG_WIDTH_VC-1:0] lt;
        bit lk;
        lk = $urandom_range(0, 1);
        lt = ($urandom_range(0, 1) != 0) ? m_tag[$urandom_range(0, WAYS_VC - 1)]
                                         : TAG_WIDTH_VC'($urandom_range(1, 20));
        do_insert(lk, lt, fresh_tag(), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
